// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding,
// wait-counter width and the access-legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam int CNT_W = 4;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // The subtract wraps, so addresses below the base land far out of range.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [32:0] limit_bytes);
    logic [31:0] off;
    off = addr - base;
    return ((addr[1:0] & WORD_ALIGN_MASK) != 2'b00) || ({1'b0, off} >= limit_bytes);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with per-byte write enables and a registered read
// port; the read register only updates on a read access.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed wait states, then a
// held response until the requester takes it.
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | counting wait states; access happens when the counter hits 0
//   RESP  | response presented until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int               AW          = $clog2(DEPTH_WORDS);
  localparam logic [32:0]      LIMIT_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam bit               ZERO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(ZERO_WAIT ? 0 : WAIT_CYCLES - 1);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             err_q, err_d;

  logic        access;
  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata, acc_off;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic [31:0] arr_rdata;

  // With no wait states the access happens on the accept edge, straight from the inputs.
  assign acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == ST_IDLE) ? req_be    : be_q;
  assign acc_off   = acc_addr - BASE_ADDR;
  assign acc_err   = addr_err(acc_addr, BASE_ADDR, LIMIT_BYTES);

  assign access = ((state_q == ST_IDLE) && req_valid && ZERO_WAIT) ||
                  ((state_q == ST_WAIT) && (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = access ? acc_err : err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_LOAD;
          state_d = ZERO_WAIT ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .en   (access && !acc_err),
    .we   (acc_we),
    .be   (acc_be),
    .addr (acc_off[AW+1:2]),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? arr_rdata : 32'h0;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32 core's load/store port: accepts one word-wide read or write request at a time over a valid/ready handshake, models a fixed number of wait states, and returns read data or a write acknowledgement over a second valid/ready channel. It is the target side of the core's data-memory access, replacing the zero-latency array when the core is run against a latency-bearing memory.

## Interface

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 2: wait states between accept and response; 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_be  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  read data; 0 for writes and errors.
- rsp_err  output  1  access error flag.

## Operation

- States: IDLE, WAIT, RESP. req_ready = (state == IDLE); decoded from state only, no combinational path from any input.
- IDLE: on req_valid && req_ready, capture we/addr/wdata/be; go to RESP if WAIT_CYCLES == 0, else to WAIT with counter loaded to WAIT_CYCLES-1.
- WAIT: counter decrements each edge; at the edge where counter == 0, perform the access and go to RESP.
- Access: error if addr[1:0] != 0 or (addr - BASE_ADDR) ≥ DEPTH_WORDS*4 (unsigned 32-bit subtract, so addresses below BASE_ADDR wrap and fail). Error: no array change, rsp_rdata = 0, rsp_err = 1. Write: update only lanes with be set; be = 0 is a legal no-op write; rsp_rdata = 0. Read: rsp_rdata = full word at index (addr - BASE_ADDR) >> 2; req_be ignored.
- RESP: rsp_valid = 1; rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready; then go to IDLE, rsp_valid low next cycle.
- One outstanding transaction; no new request is accepted while in WAIT or RESP, including the cycle a response handshakes.
- Request inputs are sampled only at the accept edge; changes afterwards have no effect.

## Timing

- Reset (async assert, sync-to-clk release by the system): state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1. Array contents not reset.
- Accept at edge E0 → rsp_valid high after edge E0+WAIT_CYCLES (WAIT_CYCLES = 0: high the cycle right after accept).
- Write takes effect at the same edge rsp_valid rises; a read accepted later observes it.
- Response handshake at edge E1 → req_ready high after E1; next accept earliest at E1+1. Minimum issue interval: WAIT_CYCLES+2 cycles with rsp_ready tied high.
- Reset asserted mid-transaction: transaction discarded; a write not yet performed is never performed; a performed write remains in the array.
- rsp_ready held low: RESP held indefinitely, outputs stable.

## Structure

- Shared package dmem_pkg: state encoding (IDLE/WAIT/RESP), WAIT counter width (4), address-check helper constants.
- Sub-module dmem_array: DEPTH_WORDS × 32 synchronous array, one port, per-byte write enable, registered read; FSM and error check stay in dmem_responder.

## Test plan

- Reset then idle: rst_n low mid-run → req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0 immediately.
- Write 32'hDEAD_BEEF to 0x10, be 4'b1111, then read 0x10, WAIT_CYCLES 2 → each rsp_valid exactly 2 cycles after accept; read returns 32'hDEAD_BEEF, rsp_err 0.
- Byte write: word 0x20 = 32'h1122_3344, write 32'hAABB_CCDD with be 4'b0101 → read returns 32'h11BB_33DD.
- Errors: read 0x13 (misaligned) and read DEPTH_WORDS*4 (out of range) → rsp_err 1, rsp_rdata 0; write with be 4'b1111 to 0x13 leaves words 0x10 and 0x14 unchanged.
- Backpressure: rsp_ready low 5 cycles in RESP → rsp_valid and data stable, req_ready 0, new req_valid not accepted until one cycle after handshake.
- WAIT_CYCLES 0 and reset during WAIT of a write to 0x30: response the cycle after accept; aborted write leaves 0x30 unchanged.
